// File: rtl/if_fetch.sv
// Instruction-fetch stage: issues pipelined imem requests under a credit limit, buffers
// returned words in order and presents {pc, inst} to ID; flush restarts at a new PC.
module if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic        id_valid_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   // RUN: every response is kept; DRAIN: responses from before a flush are dropped
   typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;
   state_t state_q, state_d;

   logic [31:0]   pc_q;
   logic [CW-1:0] out_q, disc_q, disc_d, cnt_q;
   logic [AW-1:0] tag_wp_q, tag_rp_q, buf_wp_q, buf_rp_q;
   logic [31:0]   tag_mem  [FIFO_DEPTH];
   logic [31:0]   buf_pc   [FIFO_DEPTH];
   logic [31:0]   buf_inst [FIFO_DEPTH];
   logic          credit_ok, hs, push, pop;
   logic          unused_ok;

   assign unused_ok = ^new_pc_i[1:0];

   // in-flight plus buffered words never exceed the buffer, so a response always has a slot
   assign credit_ok   = ({1'b0, out_q} + {1'b0, cnt_q}) < DEPTH_C;
   assign imem_req_o  = rst & ~flush_i & credit_ok;
   assign imem_addr_o = pc_q;
   assign hs          = imem_req_o & imem_gnt_i;
   assign push        = imem_rvalid_i & ~flush_i & (state_q == ST_RUN);
   assign pop         = ~flush_i & ~stall_i & (cnt_q != '0);

   always_comb begin
      disc_d  = disc_q;
      state_d = state_q;
      if (flush_i)
         disc_d = out_q - CW'(imem_rvalid_i);
      else if (imem_rvalid_i && (state_q == ST_DRAIN))
         disc_d = disc_q - CW'(1);
      state_d = (disc_d != '0) ? ST_DRAIN : ST_RUN;
   end

   // request-PC tags and the word buffer carry no reset; pointers and counts qualify them
   always_ff @(posedge clk) begin
      if (hs)
         tag_mem[tag_wp_q] <= pc_q;
      if (push) begin
         buf_pc[buf_wp_q]   <= tag_mem[tag_rp_q];
         buf_inst[buf_wp_q] <= imem_rdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         disc_q     <= '0;
         out_q      <= '0;
         pc_q       <= RESET_PC;
         tag_wp_q   <= '0;
         tag_rp_q   <= '0;
         buf_wp_q   <= '0;
         buf_rp_q   <= '0;
         cnt_q      <= '0;
         id_pc_o    <= '0;
         id_inst_o  <= '0;
         id_valid_o <= 1'b0;
      end else begin
         state_q <= state_d;
         disc_q  <= disc_d;
         out_q   <= out_q + CW'(hs) - CW'(imem_rvalid_i);
         // tags stay in step with the memory across flushes: stale responses still pop one
         if (hs)
            tag_wp_q <= tag_wp_q + AW'(1);
         if (imem_rvalid_i)
            tag_rp_q <= tag_rp_q + AW'(1);

         if (flush_i)
            pc_q <= {new_pc_i[31:2], 2'b00};
         else if (hs)
            pc_q <= pc_q + 32'd4;

         if (flush_i) begin
            buf_wp_q <= '0;
            buf_rp_q <= '0;
            cnt_q    <= '0;
         end else begin
            if (push)
               buf_wp_q <= buf_wp_q + AW'(1);
            if (pop)
               buf_rp_q <= buf_rp_q + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
         end

         if (flush_i) begin
            id_inst_o  <= '0;
            id_valid_o <= 1'b0;
         end else if (!stall_i) begin
            if (pop) begin
               id_pc_o    <= buf_pc[buf_rp_q];
               id_inst_o  <= buf_inst[buf_rp_q];
               id_valid_o <= 1'b1;
            end else begin
               id_inst_o  <= '0;
               id_valid_o <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: in-order pipelined memory model, ID-side scoreboard of expected PCs,
// directed phases for stream, stall, grant backpressure, flush, PC wrap and async reset.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] new_pc_i = 32'h0;
   logic        gnt = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        imem_req_o, id_valid_o;
   logic [31:0] imem_addr_o, id_pc_o, id_inst_o;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_pc, w_inst;

   int          n_cmp = 0;
   int          n_err = 0;
   int          lat = 1;
   int          gnt_cnt = 0;
   logic [31:0] exp_gnt_addr = 32'h0;
   logic [31:0] last_pc = 32'h0;
   logic [31:0] exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_wait[$];
   logic        took;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
      .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
   );

   // second instance only watches the address wrap; it never gets a response
   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_wrap (
      .clk(clk), .rst(rst), .stall_i(1'b0), .flush_i(1'b0), .new_pc_i(32'h0),
      .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(1'b1),
      .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
      .id_pc_o(w_pc), .id_inst_o(w_inst), .id_valid_o(w_valid)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic fill_exp(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 64; i++)
         exp_q.push_back(base + 32'(4 * i));
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (!id_valid_o && n < 40) begin
         tick();
         n++;
      end
      check_eq(tag, {31'b0, id_valid_o}, 32'd1);
   endtask

   // memory: in-order responses `lat` cycles after grant, word = 0x34010000 + address
   always begin
      @(posedge clk);
      if (rst && imem_req_o && gnt) begin
         check_eq("gnt_addr", imem_addr_o, exp_gnt_addr);
         exp_gnt_addr = exp_gnt_addr + 32'd4;
         pend_addr.push_back(imem_addr_o);
         pend_wait.push_back(lat);
         gnt_cnt++;
      end
      #1;
      if (!rst) begin
         rvalid = 1'b0;
         pend_addr.delete();
         pend_wait.delete();
      end else if (pend_addr.size() > 0 && pend_wait[0] <= 1) begin
         rvalid = 1'b1;
         rdata  = 32'h3401_0000 + pend_addr.pop_front();
         void'(pend_wait.pop_front());
      end else begin
         rvalid = 1'b0;
      end
      foreach (pend_wait[i])
         if (pend_wait[i] > 1)
            pend_wait[i] = pend_wait[i] - 1;
   end

   // ID-side scoreboard: every instruction accepted by ID must be the next expected PC
   always begin
      logic [31:0] e;
      @(posedge clk);
      took = rst && !stall_i && !flush_i;
      @(negedge clk);
      if (took && id_valid_o) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
         check_eq("id_pc", id_pc_o, e);
         check_eq("id_inst", id_inst_o, 32'h3401_0000 + e);
         last_pc = e;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      #3;
      check_eq("rst_valid", {31'b0, id_valid_o}, 32'd0);
      check_eq("rst_pc", id_pc_o, 32'h0);
      check_eq("rst_inst", id_inst_o, 32'h0);
      check_eq("rst_req", {31'b0, imem_req_o}, 32'd0);
      check_eq("rst_wrap_req", {31'b0, w_req}, 32'd0);
      tick();
      tick();

      // streaming from reset, plus the wrap instance's address sequence
      fill_exp(32'h0);
      exp_gnt_addr = 32'h0;
      gnt = 1'b1;
      lat = 1;
      rst = 1'b1;
      #1;
      check_eq("start_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("start_addr", imem_addr_o, 32'h0);
      check_eq("wrap_addr0", w_addr, 32'hFFFF_FFF8);
      tick();
      check_eq("addr_after_gnt", imem_addr_o, 32'h4);
      check_eq("wrap_addr1", w_addr, 32'hFFFF_FFFC);
      tick();
      check_eq("wrap_addr2", w_addr, 32'h0000_0000);
      tick();
      check_eq("first_valid", {31'b0, id_valid_o}, 32'd1);
      check_eq("first_pc", id_pc_o, 32'h0);
      check_eq("first_inst", id_inst_o, 32'h3401_0000);
      check_eq("wrap_addr3", w_addr, 32'h0000_0004);
      tick();
      check_eq("second_pc", id_pc_o, 32'h4);
      check_eq("second_inst", id_inst_o, 32'h3401_0004);
      check_eq("wrap_credit_req", {31'b0, w_req}, 32'd0);
      tick();
      tick();

      // ID stall: two more grants fill the credit, then requests stop and id_* hold
      stall_i = 1'b1;
      gnt_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_eq("stall_valid", {31'b0, id_valid_o}, 32'd1);
         check_eq("stall_pc", id_pc_o, last_pc);
      end
      check_eq("stall_req", {31'b0, imem_req_o}, 32'd0);
      check_eq("stall_gnts", 32'(gnt_cnt), 32'd2);
      stall_i = 1'b0;
      repeat (12) tick();

      // grant backpressure: request holds with a stable address while the pipe drains
      gnt = 1'b0;
      lat = 3;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_eq("nognt_req", {31'b0, imem_req_o}, 32'd1);
         check_eq("nognt_addr", imem_addr_o, exp_gnt_addr);
         tick();
      end
      check_eq("drained_valid", {31'b0, id_valid_o}, 32'd0);
      check_eq("drained_inst", id_inst_o, 32'h0);
      check_eq("drained_pc_hold", id_pc_o, last_pc);

      // flush with two requests outstanding and latency 3
      gnt = 1'b1;
      tick();
      tick();
      flush_i = 1'b1;
      new_pc_i = 32'h0000_0103;
      exp_gnt_addr = 32'h100;
      fill_exp(32'h100);
      #1;
      check_eq("flush_req", {31'b0, imem_req_o}, 32'd0);
      tick();
      flush_i = 1'b0;
      #1;
      check_eq("redir_addr", imem_addr_o, 32'h100);
      check_eq("redir_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("flush_valid", {31'b0, id_valid_o}, 32'd0);
      wait_valid("redir_first_valid");
      check_eq("redir_first_pc", id_pc_o, 32'h100);
      check_eq("redir_first_inst", id_inst_o, 32'h3401_0100);
      repeat (10) tick();

      // asynchronous reset between edges
      rst = 1'b0;
      #1;
      check_eq("arst_valid", {31'b0, id_valid_o}, 32'd0);
      check_eq("arst_pc", id_pc_o, 32'h0);
      check_eq("arst_inst", id_inst_o, 32'h0);
      check_eq("arst_req", {31'b0, imem_req_o}, 32'd0);
      tick();
      tick();
      fill_exp(32'h0);
      exp_gnt_addr = 32'h0;
      lat = 1;
      rst = 1'b1;
      #1;
      check_eq("restart_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("restart_addr", imem_addr_o, 32'h0);
      wait_valid("restart_valid");
      check_eq("restart_pc", id_pc_o, 32'h0);
      repeat (6) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
